// File: rtl/simple_axi_master_if.sv
// Single-beat AXI4 channel bundle between simple_axi_master and an interconnect.
// The master drives the valids, address/data attributes and the response readies.
interface simple_axi_master_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [7:0]  awlen;
  logic        awlock;
  logic [3:0]  awqos;

  logic        wvalid;
  logic        wready;
  logic        wlast;
  logic [63:0] wdata;
  logic [7:0]  wstrb;

  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic [7:0]  arlen;
  logic        arlock;
  logic [3:0]  arqos;

  logic        rvalid;
  logic        rready;
  logic        rlast;
  logic [63:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, awsize, awburst, awcache, awprot, awlen, awlock, awqos,
    input  awready,
    output wvalid, wlast, wdata, wstrb,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arsize, arburst, arcache, arprot, arlen, arlock, arqos,
    input  arready,
    input  rvalid, rlast, rdata, rresp,
    output rready
  );

  modport slave (
    input  awvalid, awaddr, awsize, awburst, awcache, awprot, awlen, awlock, awqos,
    output awready,
    input  wvalid, wlast, wdata, wstrb,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arsize, arburst, arcache, arprot, arlen, arlock, arqos,
    output arready,
    output rvalid, rlast, rdata, rresp,
    input  rready
  );
endinterface

// File: rtl/simple_axi_master.sv
// Single-beat AXI4 master: turns one host load/store request into one AXI read or
// write of 1/2/4/8 bytes on a 64-bit bus, with lane steering and sticky status.
module simple_axi_master (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_addr,
  input  logic [2:0]  i_wsize,
  input  logic [63:0] i_wdata,
  output logic [63:0] o_rdata,
  input  logic [1:0]  i_rw,
  output logic        o_wait,
  output logic        o_done,
  input  logic        i_clear_done,
  output logic        o_invalid,
  output logic        o_error,
  simple_axi_master_if.master m_axi
);

  typedef enum logic [1:0] {RW_IDLE, RW_WRITE, RW_READ, RW_INVALID} rw_t;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic [2:0]  size_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic [63:0] rdata_q;
  logic        aw_done_q, w_done_q;
  logic        invalid_q, error_q;

  logic        misaligned, req_bad;
  logic        aw_hs, w_hs;
  logic        awvalid_c, wvalid_c, bready_c, arvalid_c, rready_c, wait_c, done_c;
  logic        unused_rlast;

  function automatic logic [7:0] lane_mask(input logic [1:0] size);
    case (size)
      2'd0:    lane_mask = 8'h01;
      2'd1:    lane_mask = 8'h03;
      2'd2:    lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  endfunction

  // Bring the addressed lanes down to bit 0 and zero every byte beyond the access size.
  function automatic logic [63:0] extract(input logic [63:0] d, input logic [2:0] off,
                                          input logic [1:0] size);
    logic [63:0] shifted;
    logic [7:0]  keep;
    logic [63:0] res;
    shifted = d >> {off, 3'b000};
    keep    = lane_mask(size);
    res     = '0;
    for (int i = 0; i < 8; i++) begin
      if (keep[i]) res[8*i +: 8] = shifted[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    misaligned = 1'b0;
    case (i_wsize[1:0])
      2'd1:    misaligned = i_addr[0];
      2'd2:    misaligned = |i_addr[1:0];
      2'd3:    misaligned = |i_addr[2:0];
      default: misaligned = 1'b0;
    endcase
  end

  assign req_bad = (i_rw == RW_INVALID) || i_wsize[2] || misaligned;
  assign aw_hs   = awvalid_c && m_axi.awready;
  assign w_hs    = wvalid_c && m_axi.wready;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    awvalid_c = 1'b0;
    wvalid_c  = 1'b0;
    bready_c  = 1'b0;
    arvalid_c = 1'b0;
    rready_c  = 1'b0;
    wait_c    = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (i_rw != RW_IDLE) begin
          if (req_bad)               state_d = S_DONE;
          else if (i_rw == RW_WRITE) state_d = S_WR;
          else                       state_d = S_RD_ADDR;
        end
      end
      S_WR: begin
        wait_c    = 1'b1;
        awvalid_c = !aw_done_q;
        wvalid_c  = !w_done_q;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = S_WR_RESP;
      end
      S_WR_RESP: begin
        wait_c   = 1'b1;
        bready_c = 1'b1;
        if (m_axi.bvalid) state_d = S_DONE;
      end
      S_RD_ADDR: begin
        wait_c    = 1'b1;
        arvalid_c = 1'b1;
        if (m_axi.arready) state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        wait_c   = 1'b1;
        rready_c = 1'b1;
        if (m_axi.rvalid) state_d = S_DONE;
      end
      S_DONE: begin
        done_c = 1'b1;
        if (i_clear_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: the request/response registers are reset too, because their values reach the
  // AXI address/data/strobe outputs and o_rdata, which must read zero out of reset.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      invalid_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && i_rw != RW_IDLE) begin
        addr_q    <= i_addr;
        size_q    <= i_wsize;
        wdata_q   <= i_wdata << {i_addr[2:0], 3'b000};
        wstrb_q   <= lane_mask(i_wsize[1:0]) << i_addr[2:0];
        invalid_q <= req_bad;
      end
      // Per-channel handshake memory; both flags are cleared when the write phase ends.
      aw_done_q <= (state_q == S_WR && state_d == S_WR) ? (aw_done_q || aw_hs) : 1'b0;
      w_done_q  <= (state_q == S_WR && state_d == S_WR) ? (w_done_q || w_hs) : 1'b0;
      if (state_q == S_WR_RESP && m_axi.bvalid) error_q <= |m_axi.bresp;
      if (state_q == S_RD_DATA && m_axi.rvalid) begin
        error_q <= |m_axi.rresp;
        rdata_q <= extract(m_axi.rdata, addr_q[2:0], size_q[1:0]);
      end
      if (state_q == S_DONE && i_clear_done) begin
        invalid_q <= 1'b0;
        error_q   <= 1'b0;
      end
    end
  end

  assign o_rdata   = rdata_q;
  assign o_wait    = wait_c;
  assign o_done    = done_c;
  assign o_invalid = invalid_q;
  assign o_error   = error_q;

  assign m_axi.awvalid = awvalid_c;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awsize  = size_q;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awcache = 4'b0011;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awlen   = 8'h00;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awqos   = 4'h0;

  assign m_axi.wvalid  = wvalid_c;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.bready  = bready_c;

  assign m_axi.arvalid = arvalid_c;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arsize  = size_q;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arcache = 4'b0011;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arlen   = 8'h00;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arqos   = 4'h0;
  assign m_axi.rready  = rready_c;

  // Single-beat reads make rlast carry no information.
  assign unused_rlast = m_axi.rlast;

endmodule

// File: tb/tb_simple_axi_master.sv
// Bench for simple_axi_master: vector table through a one-cycle-latency AXI slave,
// scoreboard queues for expected AXI beats and read data, plus reset/clear corner cases.
module tb_simple_axi_master;

  typedef struct {
    logic [1:0]  rw;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [63:0] wdata;
    logic [1:0]  resp;
    logic [7:0]  exp_strb;
    logic [63:0] exp_wdata;
    logic [63:0] exp_rdata;
    logic        exp_invalid;
    logic        exp_error;
  } vec_t;

  localparam logic [63:0] MEM = 64'h1122334455667788;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] addr = '0;
  logic [2:0]  wsize = '0;
  logic [63:0] wdata = '0;
  logic [1:0]  rw = '0;
  logic        clear_done = 1'b0;
  logic [63:0] rdata;
  logic        busy, done, invalid, error;

  simple_axi_master_if bus();

  simple_axi_master dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_addr       (addr),
    .i_wsize      (wsize),
    .i_wdata      (wdata),
    .o_rdata      (rdata),
    .i_rw         (rw),
    .o_wait       (busy),
    .o_done       (done),
    .i_clear_done (clear_done),
    .o_invalid    (invalid),
    .o_error      (error),
    .m_axi        (bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_miss = 0;
  vec_t vecs[15];
  vec_t wr_q[$];
  vec_t rd_q[$];
  logic [1:0] resp_cfg = 2'b00;
  bit   b_hold = 1'b0;
  bit   any_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] r, input logic [31:0] a, input logic [2:0] s,
                              input logic [63:0] d, input logic [1:0] rs, input logic [7:0] st,
                              input logic [63:0] ew, input logic [63:0] er,
                              input logic inv, input logic err);
    vec_t v;
    v.rw = r; v.addr = a; v.size = s; v.wdata = d; v.resp = rs;
    v.exp_strb = st; v.exp_wdata = ew; v.exp_rdata = er;
    v.exp_invalid = inv; v.exp_error = err;
    return v;
  endfunction

  // Slave: ready one cycle after valid, response one cycle after the address/data handshakes.
  // Everything is updated on negedges; a handshake seen here completes at the next posedge.
  initial begin
    int aw_cnt, w_cnt, ar_cnt;
    bit aw_seen, w_seen, ar_seen;
    bit go_aw, go_w, go_ar, go_b, go_r;
    vec_t e;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
    aw_seen = 0; w_seen = 0; ar_seen = 0;
    go_aw = 0; go_w = 0; go_ar = 0; go_b = 0; go_r = 0;
    bus.awready = 0; bus.wready = 0; bus.arready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.rvalid = 0; bus.rresp = 0;
    bus.rdata = MEM; bus.rlast = 1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        aw_seen = 0; w_seen = 0; ar_seen = 0;
        go_aw = 0; go_w = 0; go_ar = 0; go_b = 0; go_r = 0;
        bus.awready = 0; bus.wready = 0; bus.arready = 0;
        bus.bvalid = 0; bus.rvalid = 0;
      end else begin
        if (go_aw) aw_seen = 1;
        if (go_w)  w_seen = 1;
        if (go_ar) ar_seen = 1;
        if (go_b) begin aw_seen = 0; w_seen = 0; end
        if (go_r) ar_seen = 0;
        bus.bvalid  = aw_seen && w_seen && !b_hold;
        bus.bresp   = resp_cfg;
        bus.rvalid  = ar_seen;
        bus.rresp   = resp_cfg;
        bus.awready = bus.awvalid && aw_cnt >= 1;
        bus.wready  = bus.wvalid && w_cnt >= 1;
        bus.arready = bus.arvalid && ar_cnt >= 1;
        aw_cnt = bus.awvalid ? aw_cnt + 1 : 0;
        w_cnt  = bus.wvalid ? w_cnt + 1 : 0;
        ar_cnt = bus.arvalid ? ar_cnt + 1 : 0;
        if (bus.awvalid || bus.wvalid || bus.arvalid) any_valid = 1;
        if (bus.bready) check("bready_order", {aw_seen, w_seen}, 2'b11);
        if (bus.rready) check("rready_order", ar_seen, 1'b1);

        go_aw = bus.awvalid && bus.awready;
        go_w  = bus.wvalid && bus.wready;
        go_ar = bus.arvalid && bus.arready;
        go_b  = bus.bvalid && bus.bready;
        go_r  = bus.rvalid && bus.rready;
        if (go_aw) begin
          if (wr_q.size() == 0) check("aw_unexpected", wr_q.size(), 1);
          else begin
            check("awaddr", bus.awaddr, wr_q[0].addr);
            check("awsize", bus.awsize, wr_q[0].size);
            check("aw_attr", {bus.awburst, bus.awlen, bus.awcache, bus.awprot, bus.awlock, bus.awqos},
                  {2'b01, 8'h00, 4'b0011, 3'b000, 1'b0, 4'h0});
          end
        end
        if (go_w) begin
          if (wr_q.size() == 0) check("w_unexpected", wr_q.size(), 1);
          else begin
            e = wr_q.pop_front();
            check("wdata", bus.wdata, e.exp_wdata);
            check("wstrb", bus.wstrb, e.exp_strb);
            check("wlast", bus.wlast, 1'b1);
          end
        end
        if (go_ar) begin
          if (rd_q.size() == 0) check("ar_unexpected", rd_q.size(), 1);
          else begin
            check("araddr", bus.araddr, rd_q[0].addr);
            check("arsize", bus.arsize, rd_q[0].size);
            check("ar_attr", {bus.arburst, bus.arlen, bus.arcache}, {2'b01, 8'h00, 4'b0011});
          end
        end
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    any_valid = 0;
    addr = v.addr; wsize = v.size; wdata = v.wdata; rw = v.rw; resp_cfg = v.resp;
    if (!v.exp_invalid) begin
      if (v.rw == 2'b01) wr_q.push_back(v);
      else               rd_q.push_back(v);
    end
    @(negedge clk);
    rw = 2'b00;
    check($sformatf("v%0d_done_early", idx), done, v.exp_invalid);
    check($sformatf("v%0d_wait_early", idx), busy, !v.exp_invalid);
    for (int c = 0; c < 40 && !done; c++) @(negedge clk);
    check($sformatf("v%0d_done", idx), done, 1'b1);
    check($sformatf("v%0d_wait", idx), busy, 1'b0);
    check($sformatf("v%0d_error", idx), error, v.exp_error);
    check($sformatf("v%0d_invalid", idx), invalid, v.exp_invalid);
    if (v.exp_invalid) check($sformatf("v%0d_no_valid", idx), any_valid, 1'b0);
    else if (v.rw == 2'b10 && rd_q.size() > 0) begin
      e = rd_q.pop_front();
      check($sformatf("v%0d_rdata", idx), rdata, e.exp_rdata);
    end else if (v.rw == 2'b01) check($sformatf("v%0d_w_consumed", idx), wr_q.size(), 0);
    wr_q.delete();
    rd_q.delete();
    @(negedge clk);
    check($sformatf("v%0d_done_sticky", idx), done, 1'b1);
    clear_done = 1'b1;
    @(negedge clk);
    clear_done = 1'b0;
    check($sformatf("v%0d_cleared", idx), {done, invalid, error}, 3'b000);
  endtask

  initial begin
    vecs[0]  = mk(2'b01, 32'h10000002, 3'd0, 64'hAA, 2'b00, 8'h04, 64'h0000000000AA0000, 64'h0, 0, 0);
    vecs[1]  = mk(2'b01, 32'h10000004, 3'd1, 64'hBEEF, 2'b00, 8'h30, 64'h0000BEEF00000000, 64'h0, 0, 0);
    vecs[2]  = mk(2'b01, 32'h10000000, 3'd2, 64'hDEADBEEF, 2'b00, 8'h0F, 64'h00000000DEADBEEF, 64'h0, 0, 0);
    vecs[3]  = mk(2'b01, 32'h10000000, 3'd3, MEM, 2'b00, 8'hFF, MEM, 64'h0, 0, 0);
    vecs[4]  = mk(2'b10, 32'h10000002, 3'd0, 64'h0, 2'b00, 8'h00, 64'h0, 64'h66, 0, 0);
    vecs[5]  = mk(2'b10, 32'h10000004, 3'd1, 64'h0, 2'b00, 8'h00, 64'h0, 64'h3344, 0, 0);
    vecs[6]  = mk(2'b10, 32'h10000000, 3'd2, 64'h0, 2'b00, 8'h00, 64'h0, 64'h55667788, 0, 0);
    vecs[7]  = mk(2'b10, 32'h10000000, 3'd3, 64'h0, 2'b00, 8'h00, 64'h0, MEM, 0, 0);
    vecs[8]  = mk(2'b01, 32'h10000007, 3'd0, 64'h5A, 2'b10, 8'h80, 64'h5A00000000000000, 64'h0, 0, 1);
    vecs[9]  = mk(2'b10, 32'h10000006, 3'd1, 64'h0, 2'b11, 8'h00, 64'h0, 64'h1122, 0, 1);
    vecs[10] = mk(2'b11, 32'h10000000, 3'd0, 64'h0, 2'b00, 8'h00, 64'h0, 64'h0, 1, 0);
    vecs[11] = mk(2'b10, 32'h10000001, 3'd1, 64'h0, 2'b00, 8'h00, 64'h0, 64'h0, 1, 0);
    vecs[12] = mk(2'b01, 32'h10000000, 3'd4, 64'h0, 2'b00, 8'h00, 64'h0, 64'h0, 1, 0);
    vecs[13] = mk(2'b01, 32'h10000002, 3'd2, 64'h0, 2'b00, 8'h00, 64'h0, 64'h0, 1, 0);
    vecs[14] = mk(2'b10, 32'h10000007, 3'd0, 64'h0, 2'b00, 8'h00, 64'h0, 64'h11, 0, 0);

    #1 rst_n = 1'b0;
    #2;
    check("rst_status", {busy, done, invalid, error}, 4'b0000);
    check("rst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_wstrb_addr", {bus.wstrb, bus.awaddr, bus.araddr}, 72'h0);
    check("rst_wdata", bus.wdata, 64'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);
    check("rdata_retained", rdata, 64'h11);

    // clear_done held high while the read is in flight must not disturb it.
    @(negedge clk);
    addr = 32'h10000000; wsize = 3'd2; rw = 2'b10; resp_cfg = 2'b00;
    rd_q.push_back(vecs[6]);
    @(negedge clk);
    rw = 2'b00;
    clear_done = 1'b1;
    repeat (2) @(negedge clk);
    clear_done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) @(negedge clk);
    check("clr_outside_done", done, 1'b1);
    check("clr_outside_rdata", rdata, 64'h55667788);
    rd_q.delete();
    clear_done = 1'b1;
    @(negedge clk);
    clear_done = 1'b0;

    // Reset while waiting for a write response aborts everything asynchronously.
    b_hold = 1'b1;
    @(negedge clk);
    addr = 32'h10000000; wsize = 3'd3; wdata = MEM; rw = 2'b01;
    wr_q.push_back(vecs[3]);
    @(negedge clk);
    rw = 2'b00;
    for (int c = 0; c < 40 && !bus.bready; c++) @(negedge clk);
    check("wr_resp_reached", {bus.bready, busy}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("arst_status", {busy, done, invalid, error}, 4'b0000);
    check("arst_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
    check("arst_rdata", rdata, 64'h0);
    check("arst_wdata", bus.wdata, 64'h0);
    check("arst_wstrb_addr", {bus.wstrb, bus.awaddr}, 40'h0);
    b_hold = 1'b0;
    wr_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", {busy, done}, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
